// File: rtl/rv_int_ctrl.sv
// External interrupt controller: synchronises and latches requests, prioritises them,
// and runs a one-deep request/service handshake with the core.
module rv_int_ctrl #(
  parameter int unsigned      N_SRC       = 4,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [N_SRC-1:0] EDGE_MASK   = '1,
  parameter int unsigned      ID_W        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_en,
  input  logic             glb_en,
  input  logic             int_ack,
  input  logic             mret,
  output logic             INT,
  output logic [ID_W-1:0]  int_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending
);

  localparam int unsigned N_PAD = 1 << ID_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] hist_q;
  logic [N_SRC-1:0] edge_q;
  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] eligible;
  logic [N_PAD-1:0] elig_pad;
  logic [ID_W-1:0]  sel;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~hist_q;
  assign pending  = (edge_q & EDGE_MASK) | (s & ~EDGE_MASK);
  assign eligible = pending & irq_en & {N_SRC{glb_en}};
  assign elig_pad = N_PAD'(eligible);

  // Synchroniser chain plus one-cycle history for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      hist_q <= s;
    end
  end

  always_comb begin
    ack_clr = '0;
    if (state == REQ && int_ack) ack_clr = N_SRC'(1) << int_id;
  end

  // Edge latches: a new edge beats a same-cycle acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_q <= '0;
    else        edge_q <= (edge_q & ~ack_clr) | (rise & EDGE_MASK);
  end

  // Fixed priority, lowest index wins
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      INT        <= 1'b0;
      int_id     <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            state  <= REQ;
            INT    <= 1'b1;
            int_id <= sel;
          end
        end
        REQ: begin
          if (int_ack) begin
            state      <= SERVICE;
            INT        <= 1'b0;
            in_service <= 1'b1;
          end else if (!elig_pad[int_id]) begin
            state <= IDLE;
            INT   <= 1'b0;
          end
        end
        SERVICE: begin
          if (mret) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          INT        <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule
